// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response channel,
// ID-stage handoff and the redirect/halt controls from later stages.
// master = fetch queue side, slave = memory/pipeline environment side.
interface mips_fetch_queue_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;
  logic              id_ready;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              halt;

  modport master (
    output imem_req, imem_addr, id_valid, id_ir, id_npc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, br_taken, br_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_ir, id_npc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, br_taken, br_target, halt
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS instruction fetch queue: issues in-order word fetches under a credit
// limit, buffers returned instructions with their next-PC, and handles
// taken-branch redirects (dropping stale responses) and sticky halt.
module mips_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic                clk1,
  input logic                rst_n,
  mips_fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      ir_mem_q [DEPTH];
  logic [31:0]      ir_mem_d [DEPTH];
  logic [31:0]      npc_mem_q [DEPTH];
  logic [31:0]      npc_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             halted_q, halted_d;

  logic credit_ok;
  logic req;
  logic issue;
  logic rsp;
  logic push;
  logic valid;
  logic pop;

  // Handshake decode and output drive; reset gates the request so nothing issues while held.
  always_comb begin
    credit_ok = ({1'b0, count_q} + {1'b0, out_q}) < DEPTH_C;
    req       = rst_n && !halted_q && !bus.br_taken && !bus.halt && credit_ok;
    issue     = req && bus.imem_gnt;
    rsp       = bus.imem_rvalid && (out_q != '0);
    push      = rsp && (discard_q == '0) && !halted_q && !bus.br_taken;
    valid     = (count_q != '0) && !halted_q;
    pop       = valid && bus.id_ready && !bus.br_taken;

    bus.imem_req  = req;
    bus.imem_addr = fetch_pc_q[ADDR_W-1:0];
    bus.id_valid  = valid;
    bus.id_ir     = ir_mem_q[rd_ptr_q];
    bus.id_npc    = npc_mem_q[rd_ptr_q];
  end

  // Next-state: PCs, credits, discard tracking, FIFO pointers/storage, halt.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    ir_mem_d   = ir_mem_q;
    npc_mem_d  = npc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_d      = out_q + CNT_W'(issue) - CNT_W'(rsp);
    discard_d  = discard_q;
    halted_d   = halted_q | bus.halt;

    if (issue) fetch_pc_d = fetch_pc_q + 32'd1;

    if (push) begin
      ir_mem_d[wr_ptr_q]  = bus.imem_rdata;
      npc_mem_d[wr_ptr_q] = resp_pc_q + 32'd1;
      resp_pc_d           = resp_pc_q + 32'd1;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (rsp && discard_q != '0) discard_d = discard_q - CNT_W'(1);

    if (bus.br_taken) begin
      fetch_pc_d = bus.br_target;
      resp_pc_d  = bus.br_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // outstanding already includes any fetches still marked for discard,
      // so every response in flight (minus the one landing now) is stale.
      discard_d  = out_q - CNT_W'(rsp);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      ir_mem_q   <= '{default: '0};
      npc_mem_q  <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      discard_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      ir_mem_q   <= ir_mem_d;
      npc_mem_q  <= npc_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
    end
  end

endmodule
